// File: rtl/tour_cmd_seq.sv
// Knight's-tour move sequencer: turns each one-hot solver move into a vertical then a horizontal robot leg.
// Optional feature: define TOUR_FANFARE_EN to issue horizontal legs with the fanfare opcode.
module tour_cmd_seq #(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic        busy,
    output logic        tour_done,
    output logic        err
);

    localparam logic [3:0] OP_V = 4'b0010;
`ifdef TOUR_FANFARE_EN
    localparam logic [3:0] OP_H = 4'b0011;
`else
    localparam logic [3:0] OP_H = 4'b0010;
`endif
    localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;
    localparam logic [7:0] HDG_W = 8'h3F;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND_V,
        WAIT_V,
        SEND_H,
        WAIT_H
    } state_t;

    state_t     state;
    logic [7:0] move_reg;
    logic       move_one_hot;

    // Heading and square count of the dy component, {heading, squares}.
    function automatic logic [11:0] leg_v(input logic [7:0] m);
        logic [11:0] leg;
        case (m)
            8'h01, 8'h02: leg = {HDG_N, 4'd2};
            8'h04, 8'h80: leg = {HDG_N, 4'd1};
            8'h08, 8'h40: leg = {HDG_S, 4'd1};
            8'h10, 8'h20: leg = {HDG_S, 4'd2};
            default:      leg = 12'h000;
        endcase
        return leg;
    endfunction

    function automatic logic [11:0] leg_h(input logic [7:0] m);
        logic [11:0] leg;
        case (m)
            8'h01, 8'h20: leg = {HDG_E, 4'd1};
            8'h02, 8'h10: leg = {HDG_W, 4'd1};
            8'h04, 8'h08: leg = {HDG_W, 4'd2};
            8'h40, 8'h80: leg = {HDG_E, 4'd2};
            default:      leg = 12'h000;
        endcase
        return leg;
    endfunction

    assign move_one_hot = (move != 8'h00) && ((move & (move - 8'h01)) == 8'h00);
    assign busy         = (state != IDLE);

    // Each handshake input is only honoured in the state that expects it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mv_indx   <= 5'd0;
            cmd       <= 16'h0000;
            cmd_rdy   <= 1'b0;
            tour_done <= 1'b0;
            err       <= 1'b0;
            move_reg  <= 8'h00;
        end else begin
            tour_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_tour) begin
                        mv_indx <= 5'd0;
                        err     <= 1'b0;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    move_reg <= move;
                    if (move_one_hot) begin
                        cmd     <= {OP_V, leg_v(move)};
                        cmd_rdy <= 1'b1;
                        state   <= SEND_V;
                    end else begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                SEND_V: begin
                    if (clr_cmd_rdy) begin
                        cmd_rdy <= 1'b0;
                        state   <= WAIT_V;
                    end
                end
                WAIT_V: begin
                    if (send_resp) begin
                        cmd     <= {OP_H, leg_h(move_reg)};
                        cmd_rdy <= 1'b1;
                        state   <= SEND_H;
                    end
                end
                SEND_H: begin
                    if (clr_cmd_rdy) begin
                        cmd_rdy <= 1'b0;
                        state   <= WAIT_H;
                    end
                end
                WAIT_H: begin
                    if (send_resp) begin
                        if (mv_indx == LAST_INDX) begin
                            tour_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            mv_indx <= mv_indx + 5'd1;
                            state   <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
